// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if : signal bundle between a serial line source and the UART
// receiver.
//   rx          serial line, idle high (driven by the source / master)
//   data_out    last correctly received word, bit 0 = first bit on the line
//   data_valid  one-cycle pulse when data_out is updated
//   frame_err   one-cycle pulse when the stop bit samples low
//   busy        receiver is inside a frame (state != IDLE)
// The master modport is the line driver / consumer; the slave modport is
// the receiver.
// ---------------------------------------------------------------------------
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output rx,
      input  data_out,
      input  data_valid,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  rx,
      output data_out,
      output data_valid,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1-style UART receiver (1 start, DATA_BITS data LSB first,
// no parity, 1 stop bit).
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_if slave: rx in; data_out, data_valid, frame_err, busy out
// The line is double-flopped, the start bit is confirmed at mid-bit, and
// every following bit is sampled one full bit period after the previous
// sample, i.e. near its centre.
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.slave bus
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     clk_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] data_out_r;
   logic                 data_valid_r;
   logic                 frame_err_r;
   logic                 busy_r;

   logic                 rx_p0;
   logic                 rx_s;

   // ---- stage p0/p1: two-flop synchronizer, resets to idle-high ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_p0 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_p0 <= bus.rx;
         rx_s  <= rx_p0;
      end
   end

   // ---- frame FSM: operates on the synchronized line only ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         clk_cnt      <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         data_out_r   <= '0;
         data_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         data_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  clk_cnt <= '0;
                  busy_r  <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               if (clk_cnt == HALF) begin
                  if (!rx_s) begin
                     clk_cnt <= '0;
                     bit_idx <= '0;
                     state   <= DATA;
                  end else begin
                     // Line went back high before mid-bit: treat as a glitch.
                     busy_r <= 1'b0;
                     state  <= IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (clk_cnt == LAST) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + IDX_ONE;
                  if (bit_idx == IDX_LAST) begin
                     state <= STOP;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_ONE;
               end
            end
            STOP: begin
               if (clk_cnt == LAST) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     // Leave at the stop-bit centre so a start edge right
                     // after a single stop bit is still caught.
                     data_out_r   <= shreg;
                     data_valid_r <= 1'b1;
                     busy_r       <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     frame_err_r <= 1'b1;
                     state       <= WAIT_IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_ONE;
               end
            end
            WAIT_IDLE: begin
               // A line held low (break) must not look like a new start.
               if (rx_s) begin
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.data_out   = data_out_r;
   assign bus.data_valid = data_valid_r;
   assign bus.frame_err  = frame_err_r;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : scoreboard bench for uart_rx (CLKS_PER_BIT=16, DATA_BITS=8).
// Frames are queued as expected events when driven; a monitor pops and
// compares on every data_valid / frame_err pulse.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB = 16;

   typedef struct {
      logic       err;
      logic [7:0] data;
   } evt_t;

   logic clk;
   logic rst_n;

   uart_rx_if #(.DATA_BITS(8)) bus ();

   uart_rx #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   evt_t       sb_q[$];
   int         valid_cyc[$];
   logic [7:0] last_good = 8'h00;
   logic       prev_pulse = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: pulses are sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n && (bus.data_valid || bus.frame_err)) begin
         evt_t e;
         check("dv_fe_exclusive", {31'd0, bus.data_valid & bus.frame_err}, 32'd0);
         check("pulse_one_cycle", {31'd0, prev_pulse}, 32'd0);
         if (bus.data_valid) valid_cyc.push_back(cyc);
         if (sb_q.size() == 0) begin
            check("unexpected_event", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("event_kind_ferr", {31'd0, bus.frame_err}, {31'd0, e.err});
            check("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
         end
      end
      prev_pulse = rst_n && (bus.data_valid || bus.frame_err);
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Caller is 1 time unit after a posedge; each bit lasts 'per' cycles.
   task automatic send_frame(input logic [7:0] d, input int per,
                             input logic stop_bit, input bit chk_busy);
      evt_t e;
      if (stop_bit) begin
         e.err = 1'b0;
         e.data = d;
         last_good = d;
      end else begin
         e.err = 1'b1;
         e.data = last_good;
      end
      sb_q.push_back(e);
      bus.rx = 1'b0;
      for (int i = 1; i <= per; i++) begin
         @(posedge clk);
         #1;
         if (chk_busy && i == 2) check("busy_before_detect", {31'd0, bus.busy}, 32'd0);
         if (chk_busy && i == 3) check("busy_at_detect", {31'd0, bus.busy}, 32'd1);
      end
      for (int b = 0; b < 8; b++) begin
         bus.rx = d[b];
         wait_cycles(per);
      end
      bus.rx = stop_bit;
      wait_cycles(per);
   endtask

   initial begin
      bit saw_busy;
      int n0;
      bus.rx = 1'b1;
      rst_n  = 1'b0;
      wait_cycles(4);
      check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
      check("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
      check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      rst_n = 1'b1;
      wait_cycles(10);

      // Single frame 0xA5
      send_frame(8'hA5, CPB, 1'b1, 1'b1);
      wait_cycles(10);
      check("a5_data_out", {24'd0, bus.data_out}, 32'h A5);
      check("a5_busy_idle", {31'd0, bus.busy}, 32'd0);

      // Glitch: 3 cycles low
      saw_busy = 1'b0;
      bus.rx = 1'b0;
      wait_cycles(3);
      bus.rx = 1'b1;
      for (int i = 0; i < 30; i++) begin
         wait_cycles(1);
         if (bus.busy) saw_busy = 1'b1;
      end
      check("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
      check("glitch_busy_idle", {31'd0, bus.busy}, 32'd0);
      check("glitch_data_out", {24'd0, bus.data_out}, {24'd0, last_good});

      // Framing error, line held low, then 0x55
      send_frame(8'h3C, CPB, 1'b0, 1'b0);
      wait_cycles(40);
      check("held_low_busy", {31'd0, bus.busy}, 32'd1);
      check("held_low_data_out", {24'd0, bus.data_out}, 32'h A5);
      bus.rx = 1'b1;
      wait_cycles(5);
      check("after_break_idle", {31'd0, bus.busy}, 32'd0);
      wait_cycles(10);
      send_frame(8'h55, CPB, 1'b1, 1'b0);
      wait_cycles(10);
      check("x55_data_out", {24'd0, bus.data_out}, 32'h 55);

      // Back-to-back 0x00 then 0xFF
      n0 = valid_cyc.size();
      send_frame(8'h00, CPB, 1'b1, 1'b0);
      send_frame(8'hFF, CPB, 1'b1, 1'b0);
      wait_cycles(10);
      check("b2b_pulse_count", valid_cyc.size() - n0, 32'd2);
      if (valid_cyc.size() - n0 == 2)
         check("b2b_spacing", valid_cyc[n0+1] - valid_cyc[n0], 32'd160);
      check("b2b_data_out", {24'd0, bus.data_out}, 32'h FF);

      // Reset during 4th data bit of 0x81
      bus.rx = 1'b0;
      wait_cycles(CPB);
      bus.rx = 1'b1;
      wait_cycles(CPB);
      bus.rx = 1'b0;
      wait_cycles(CPB);
      wait_cycles(CPB);
      wait_cycles(CPB / 2);
      check("midframe_busy", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      bus.rx = 1'b1;
      #1;
      check("midrst_data_out", {24'd0, bus.data_out}, 32'd0);
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_valid", {31'd0, bus.data_valid}, 32'd0);
      wait_cycles(3);
      rst_n = 1'b1;
      last_good = 8'h00;
      wait_cycles(20);
      check("postrst_busy", {31'd0, bus.busy}, 32'd0);
      check("postrst_data_out", {24'd0, bus.data_out}, 32'd0);
      send_frame(8'h7E, CPB, 1'b1, 1'b0);
      wait_cycles(10);
      check("x7e_data_out", {24'd0, bus.data_out}, 32'h 7E);

      // Baud tolerance
      send_frame(8'hC3, 15, 1'b1, 1'b0);
      wait_cycles(20);
      check("baud15_data_out", {24'd0, bus.data_out}, 32'h C3);
      send_frame(8'h00, CPB, 1'b1, 1'b0);
      wait_cycles(10);
      send_frame(8'hC3, 17, 1'b1, 1'b0);
      wait_cycles(20);
      check("baud17_data_out", {24'd0, bus.data_out}, 32'h C3);

      wait_cycles(50);
      check("scoreboard_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that consumes the serial stream produced by the TX shift-register stage. It runs at 1 start bit, DATA_BITS data bits sent LSB first, no parity, and 1 stop bit. The block synchronizes the line, validates the start bit at mid-bit, and samples each bit near its centre using a per-bit cycle counter. Each good frame is presented as a parallel word with a one-cycle valid pulse; a bad stop bit is flagged as a framing error.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); legal range >= 4.
DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
rx  input  1  serial line, asynchronous to clk, idle high.
data_out  output  DATA_BITS  last correctly received word; bit 0 = first data bit on the line.
data_valid  output  1  one-cycle pulse when data_out is updated.
frame_err  output  1  one-cycle pulse when the stop bit samples low.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; counters = 0; shift register = 0.
  - sync flops = 1, so the line reads idle.
  - data_out = 0; data_valid = 0; frame_err = 0; busy = 0.
- Synchronizer: 2-flop on rx gives rx_s, with 2-cycle latency. All decisions use rx_s only.
- Counter: clk_cnt, width clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2 - 1, integer division.
- IDLE:
  - On rx_s == 0: clk_cnt = 0, go to START.
  - Otherwise stay in IDLE.
- START:
  - Increment clk_cnt until it equals HALF.
  - At that point, rx_s == 0 means a valid start: clk_cnt = 0, bit_idx = 0, go to DATA.
  - rx_s == 1 means a glitch: go to IDLE with no pulse.
- DATA:
  - Increment clk_cnt up to CLKS_PER_BIT-1.
  - At that point, shift right: shreg = {rx_s, shreg[DATA_BITS-1:1]}. Then clk_cnt = 0 and bit_idx += 1.
  - After the bit with bit_idx == DATA_BITS-1 is sampled, go to STOP.
- STOP:
  - Increment clk_cnt up to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s == 1: data_out = shreg, data_valid = 1 for exactly 1 cycle, go to IDLE.
  - rx_s == 0: frame_err = 1 for exactly 1 cycle, data_out unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s == 1, then go to IDLE. This covers breaks and line held low.
  - Prevents a held-low line from being taken as a new start.
- Timing:
  - Start sample lands 2 + HALF + 1 cycles after rx falls.
  - Each data and stop sample lands CLKS_PER_BIT cycles after the previous sample, i.e. mid-bit.
  - data_valid rises on the cycle after the stop sample.
- Back-to-back frames:
  - The FSM re-enters IDLE at the stop-bit centre, so a start edge right after a single stop bit is detected.
  - No idle gap is required between frames.
- data_valid and frame_err are never high together. Neither is ever high for more than one cycle.
- No flow control:
  - The consumer must capture data_out on data_valid.
  - data_out holds its value until the next good frame.
- Reset mid-frame: immediate return to IDLE, no pulse, data_out = 0.

Test Plan:
Bench uses CLKS_PER_BIT=16, DATA_BITS=8, and drives rx at 16 clk per bit.
- Single frame 0xA5, idle-high before and after -> one data_valid pulse; data_out = 0xA5; busy high from 3 cycles after the start edge until IDLE; frame_err stays 0.
- rx low for 3 cycles, then high (glitch) -> busy pulses briefly; returns to IDLE; no data_valid; no frame_err; data_out unchanged.
- Frame 0x3C with stop bit driven 0, line held low 40 cycles, then a frame 0x55 -> frame_err one pulse; data_out stays at its prior value; no start detected while held low; then data_valid with data_out = 0x55.
- Back-to-back frames 0x00 then 0xFF, one stop bit each, no gap -> two data_valid pulses 160 cycles apart; data_out = 0x00, then 0xFF.
- Assert rst_n low during the 4th data bit of frame 0x81, release, then send 0x7E -> no pulse for the aborted frame; data_out = 0 after reset; then data_valid with 0x7E.
- Baud tolerance: frame 0xC3 sent with bit period 15 and then 17 cycles -> both received correctly as 0xC3.
